// File: rtl/traffic_intersection_ctrl.sv
// Two-way intersection sequencer with a pedestrian walk phase.
// Moore light outputs; one down-counting timer shared by all phases.
module traffic_intersection_ctrl #(
  parameter int CW       = 4,
  parameter int GREEN_T  = 15,
  parameter int YELLOW_T = 5,
  parameter int ALLRED_T = 2,
  parameter int PED_T    = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          car_ew,
  input  logic          ped_req,
  output logic [2:0]    ns_light,
  output logic [2:0]    ew_light,
  output logic          walk,
  output logic [CW-1:0] count,
  output logic [2:0]    phase
);

  typedef enum logic [2:0] {
    NS_G = 3'd0,
    NS_Y = 3'd1,
    AR_A = 3'd2,
    EW_G = 3'd3,
    EW_Y = 3'd4,
    AR_B = 3'd5,
    WALK = 3'd6
  } state_e;

  localparam logic [CW-1:0] G_LD  = CW'(GREEN_T - 1);
  localparam logic [CW-1:0] Y_LD  = CW'(YELLOW_T - 1);
  localparam logic [CW-1:0] AR_LD = CW'(ALLRED_T - 1);
  localparam logic [CW-1:0] P_LD  = CW'(PED_T - 1);

  localparam logic [2:0] LG = 3'b001;
  localparam logic [2:0] LY = 3'b010;
  localparam logic [2:0] LR = 3'b100;

  state_e        state_q, state_d;
  logic [CW-1:0] count_q, count_d;
  logic          ped_pend_q, ped_pend_d;
  logic          next_ew_q, next_ew_d;
  logic          done;

  assign done = (count_q == '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= NS_G;
      count_q    <= G_LD;
      ped_pend_q <= 1'b0;
      next_ew_q  <= 1'b1;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      ped_pend_q <= ped_pend_d;
      next_ew_q  <= next_ew_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    count_d   = count_q - 1'b1;
    next_ew_d = next_ew_q;
    unique case (state_q)
      NS_G: begin
        if (done) begin
          if (car_ew | ped_pend_q) begin
            state_d = NS_Y;
            count_d = Y_LD;
          end else begin
            count_d = '0;
          end
        end
      end
      NS_Y: if (done) begin
        state_d = AR_A;
        count_d = AR_LD;
      end
      AR_A: if (done) begin
        if (ped_pend_q) begin
          state_d   = WALK;
          count_d   = P_LD;
          next_ew_d = 1'b1;
        end else begin
          state_d = EW_G;
          count_d = G_LD;
        end
      end
      EW_G: if (done) begin
        state_d = EW_Y;
        count_d = Y_LD;
      end
      EW_Y: if (done) begin
        state_d = AR_B;
        count_d = AR_LD;
      end
      AR_B: if (done) begin
        if (ped_pend_q) begin
          state_d   = WALK;
          count_d   = P_LD;
          next_ew_d = 1'b0;
        end else begin
          state_d = NS_G;
          count_d = G_LD;
        end
      end
      WALK: if (done) begin
        state_d = next_ew_q ? EW_G : NS_G;
        count_d = G_LD;
      end
      default: begin
        state_d = NS_G;
        count_d = G_LD;
      end
    endcase

    // Entering WALK consumes the request; a same-cycle press is absorbed.
    ped_pend_d = ped_pend_q;
    if (state_d == WALK && state_q != WALK) begin
      ped_pend_d = 1'b0;
    end else if (ped_req && state_q != WALK) begin
      ped_pend_d = 1'b1;
    end
  end

  always_comb begin
    ns_light = LR;
    ew_light = LR;
    walk     = 1'b0;
    unique case (state_q)
      NS_G:    ns_light = LG;
      NS_Y:    ns_light = LY;
      EW_G:    ew_light = LG;
      EW_Y:    ew_light = LY;
      WALK:    walk     = 1'b1;
      default: ;
    endcase
  end

  assign count = count_q;
  assign phase = state_q;

endmodule

// File: tb/tb_traffic_intersection_ctrl.sv
// Directed and random scenarios for the intersection sequencer.
// Each task checks its own expectations inline.
module tb_traffic_intersection_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       car_ew;
  logic       ped_req;
  logic [2:0] ns_light;
  logic [2:0] ew_light;
  logic       walk;
  logic [3:0] count;
  logic [2:0] phase;

  int n_tests = 0;
  int n_fail  = 0;

  traffic_intersection_ctrl dut (
    .clk      (clk),
    .reset    (reset),
    .car_ew   (car_ew),
    .ped_req  (ped_req),
    .ns_light (ns_light),
    .ew_light (ew_light),
    .walk     (walk),
    .count    (count),
    .phase    (phase)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    car_ew  = 1'b0;
    ped_req = 1'b0;
    do_reset();
    n_tests++;
    if ({phase, count, ns_light, ew_light, walk} !==
        {3'd0, 4'd14, 3'b001, 3'b100, 1'b0}) begin
      n_fail++;
      $display("FAIL reset: ph=%0d cnt=%0d ns=%b ew=%b w=%b exp 0 14 001 100 0",
               phase, count, ns_light, ew_light, walk);
    end
  endtask

  task automatic test_idle_hold();
    logic [3:0] ec;
    car_ew  = 1'b0;
    ped_req = 1'b0;
    do_reset();
    for (int c = 0; c < 30; c++) begin
      ec = (c < 15) ? 4'(14 - c) : 4'd0;
      n_tests++;
      if (phase !== 3'd0 || count !== ec || ns_light !== 3'b001) begin
        n_fail++;
        $display("FAIL idle c=%0d: ph=%0d cnt=%0d ns=%b exp ph=0 cnt=%0d ns=001",
                 c, phase, count, ns_light, ec);
      end
      tick();
    end
  endtask

  task automatic test_car_cycle();
    logic [2:0] ep;
    car_ew  = 1'b1;
    ped_req = 1'b0;
    do_reset();
    for (int c = 0; c <= 44; c++) begin
      ep = (c < 15) ? 3'd0 : (c < 20) ? 3'd1 : (c < 22) ? 3'd2 :
           (c < 37) ? 3'd3 : (c < 42) ? 3'd4 : (c < 44) ? 3'd5 : 3'd0;
      n_tests++;
      if (phase !== ep || walk !== 1'b0) begin
        n_fail++;
        $display("FAIL car_cycle c=%0d: ph=%0d walk=%b exp ph=%0d walk=0",
                 c, phase, walk, ep);
      end
      tick();
    end
  endtask

  task automatic test_ped_ns();
    logic [2:0] ep;
    car_ew = 1'b0;
    do_reset();
    for (int c = 0; c <= 30; c++) begin
      ped_req = (c == 3);
      ep = (c < 15) ? 3'd0 : (c < 20) ? 3'd1 : (c < 22) ? 3'd2 :
           (c < 30) ? 3'd6 : 3'd3;
      n_tests++;
      if (phase !== ep || walk !== (ep == 3'd6)) begin
        n_fail++;
        $display("FAIL ped_ns c=%0d: ph=%0d walk=%b exp ph=%0d", c, phase, walk, ep);
      end
      if (ep == 3'd6) begin
        n_tests++;
        if (count !== 4'(29 - c) || ns_light !== 3'b100 || ew_light !== 3'b100) begin
          n_fail++;
          $display("FAIL ped_walk c=%0d: cnt=%0d ns=%b ew=%b exp cnt=%0d 100 100",
                   c, count, ns_light, ew_light, 29 - c);
        end
      end
      tick();
    end
    n_tests++;
    if (ew_light !== 3'b001 && phase !== 3'd3) begin
      n_fail++;
      $display("FAIL ped_ns_ewg: ew=%b exp 001", ew_light);
    end
    ped_req = 1'b0;
  endtask

  task automatic test_ped_ew();
    logic [2:0] ep;
    car_ew = 1'b1;
    do_reset();
    for (int c = 0; c <= 74; c++) begin
      ped_req = (c == 25) || (c == 46);
      ep = (c < 15) ? 3'd0 : (c < 20) ? 3'd1 : (c < 22) ? 3'd2 :
           (c < 37) ? 3'd3 : (c < 42) ? 3'd4 : (c < 44) ? 3'd5 :
           (c < 52) ? 3'd6 : (c < 67) ? 3'd0 : (c < 72) ? 3'd1 :
           (c < 74) ? 3'd2 : 3'd3;
      n_tests++;
      if (phase !== ep || walk !== (ep == 3'd6)) begin
        n_fail++;
        $display("FAIL ped_ew c=%0d: ph=%0d walk=%b exp ph=%0d", c, phase, walk, ep);
      end
      tick();
    end
    ped_req = 1'b0;
  endtask

  task automatic test_mid_reset();
    car_ew  = 1'b1;
    ped_req = 1'b0;
    do_reset();
    for (int c = 0; c < 30; c++) begin
      ped_req = (c == 28);
      tick();
    end
    ped_req = 1'b0;
    n_tests++;
    if (phase !== 3'd3 || count !== 4'd6) begin
      n_fail++;
      $display("FAIL mid_pre: ph=%0d cnt=%0d exp 3 6", phase, count);
    end
    reset = 1'b1;
    tick();
    reset  = 1'b0;
    car_ew = 1'b0;
    n_tests++;
    if (phase !== 3'd0 || count !== 4'd14 || walk !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_reset: ph=%0d cnt=%0d walk=%b exp 0 14 0", phase, count, walk);
    end
    for (int c = 0; c < 20; c++) tick();
    n_tests++;
    if (phase !== 3'd0 || count !== 4'd0) begin
      n_fail++;
      $display("FAIL mid_pend_clr: ph=%0d cnt=%0d exp 0 0", phase, count);
    end
  endtask

  task automatic test_random();
    logic [2:0] prev;
    int         len;
    int         tl[7];
    tl = '{15, 5, 2, 15, 5, 2, 8};
    car_ew  = 1'b0;
    ped_req = 1'b0;
    do_reset();
    prev = phase;
    len  = 0;
    for (int c = 0; c < 10000; c++) begin
      n_tests++;
      if ((ns_light != 3'b100 && ew_light != 3'b100) ||
          !$onehot(ns_light) || !$onehot(ew_light) || phase == 3'd7) begin
        n_fail++;
        $display("FAIL rand_safety c=%0d: ns=%b ew=%b ph=%0d", c, ns_light, ew_light, phase);
      end
      if (phase == prev) begin
        len++;
      end else begin
        n_tests++;
        if ((prev == 3'd0) ? (len < 15) : (len != tl[prev])) begin
          n_fail++;
          $display("FAIL rand_len c=%0d: ph=%0d len=%0d exp %0d", c, prev, len, tl[prev]);
        end
        n_tests++;
        if (count !== 4'(tl[phase] - 1)) begin
          n_fail++;
          $display("FAIL rand_load c=%0d: ph=%0d cnt=%0d exp %0d",
                   c, phase, count, tl[phase] - 1);
        end
        prev = phase;
        len  = 1;
      end
      car_ew  = ($urandom_range(0, 3) == 0);
      ped_req = ($urandom_range(0, 19) == 0);
      tick();
    end
    car_ew  = 1'b0;
    ped_req = 1'b0;
  endtask

  initial begin
    reset   = 1'b1;
    car_ew  = 1'b0;
    ped_req = 1'b0;
    #1;
    test_reset();
    test_idle_hold();
    test_car_cycle();
    test_ped_ns();
    test_ped_ew();
    test_mid_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
